// File: rtl/attention_stream_feeder.sv
// Tile feeder for attention_core: replays host-loaded Q/K/V beats, captures result beats; readback 1-cycle latency.
// Send beats hold data under m_ready stall; s_ready drops once len results are taken; RUN aborts after TIMEOUT idle cycles.
module attention_stream_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 1024,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr_en,
    input  logic [1:0]            cfg_wr_sel,
    input  logic [AW-1:0]         cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wr_data,
    input  logic                  start,
    input  logic [AW:0]           len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_q_data,
    output logic [DATA_WIDTH-1:0] m_k_data,
    output logic [DATA_WIDTH-1:0] m_v_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [AW-1:0]         res_rd_addr,
    output logic [DATA_WIDTH-1:0] res_rd_data
);

    localparam int             IW        = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]    DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [IW-1:0]  TIMEOUT_C = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_q_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_k_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_v_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_res_mem [DEPTH];

    logic [AW:0]           r_len;
    logic [AW:0]           r_send_cnt;
    logic [AW:0]           r_recv_cnt;
    logic [IW-1:0]         r_idle_cnt;
    logic                  r_m_valid;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_res_rd_data;

    logic                  w_s_ready;
    logic                  w_send_fire;
    logic                  w_recv_fire;
    logic [AW:0]           w_send_nxt;
    logic [AW:0]           w_recv_nxt;
    logic [IW-1:0]         w_idle_nxt;
    logic                  w_len_ok;
    logic                  w_start_ok;
    logic                  w_start_bad;
    logic                  w_timeout;
    logic                  w_cfg_we;
    logic                  w_res_we;
    logic [AW-1:0]         w_send_idx;
    logic [AW-1:0]         w_recv_idx;

    assign w_s_ready   = (r_state == S_RUN) && (r_recv_cnt < r_len);
    assign w_send_fire = r_m_valid && m_ready;
    assign w_recv_fire = w_s_ready && s_valid;
    assign w_send_nxt  = r_send_cnt + {{AW{1'b0}}, w_send_fire};
    assign w_recv_nxt  = r_recv_cnt + {{AW{1'b0}}, w_recv_fire};
    assign w_idle_nxt  = (w_send_fire || w_recv_fire) ? '0 :
                         (r_idle_cnt == TIMEOUT_C)    ? r_idle_cnt :
                                                        r_idle_cnt + 1'b1;
    assign w_len_ok    = (len != '0) && (len <= DEPTH_C);
    assign w_send_idx  = r_send_cnt[AW-1:0];
    assign w_recv_idx  = r_recv_cnt[AW-1:0];
    assign w_cfg_we    = rst_n && cfg_wr_en && (r_state != S_RUN);
    assign w_res_we    = rst_n && w_recv_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion looks at post-handshake counts so DONE follows the final beat directly.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_state_nxt = S_RUN;
                        w_start_ok  = 1'b1;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if ((w_send_nxt == r_len) && (w_recv_nxt == r_len)) begin
                    w_state_nxt = S_DONE;
                end else if (w_idle_nxt == TIMEOUT_C) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len         <= '0;
            r_send_cnt    <= '0;
            r_recv_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_m_valid     <= 1'b0;
            r_err         <= 1'b0;
            r_res_rd_data <= '0;
        end else begin
            r_res_rd_data <= ({1'b0, res_rd_addr} < DEPTH_C) ? r_res_mem[res_rd_addr] : '0;
            if (w_start_ok) begin
                r_len      <= len;
                r_send_cnt <= '0;
                r_recv_cnt <= '0;
                r_idle_cnt <= '0;
                r_m_valid  <= 1'b1;
                r_err      <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_send_cnt <= w_send_nxt;
                r_recv_cnt <= w_recv_nxt;
                r_idle_cnt <= w_idle_nxt;
                r_m_valid  <= !w_timeout && (w_send_nxt < r_len);
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_m_valid <= 1'b0;
            end
            if (w_start_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Operand and result storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_cfg_we) begin
            case (cfg_wr_sel)
                2'd0:    r_q_mem[cfg_wr_addr] <= cfg_wr_data;
                2'd1:    r_k_mem[cfg_wr_addr] <= cfg_wr_data;
                2'd2:    r_v_mem[cfg_wr_addr] <= cfg_wr_data;
                default: ;
            endcase
        end
        if (w_res_we) begin
            r_res_mem[w_recv_idx] <= s_data;
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign err         = r_err;
    assign m_valid     = r_m_valid;
    assign s_ready     = w_s_ready;
    assign m_q_data    = r_m_valid ? r_q_mem[w_send_idx] : '0;
    assign m_k_data    = r_m_valid ? r_k_mem[w_send_idx] : '0;
    assign m_v_data    = r_m_valid ? r_v_mem[w_send_idx] : '0;
    assign res_rd_data = r_res_rd_data;

endmodule

// File: tb/tb_attention_stream_feeder.sv
// Bench for attention_stream_feeder: transaction-level model of the run (beats owed/received, quiet time)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_attention_stream_feeder;

    localparam int DW      = 16;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_wr_en;
    logic [1:0]    cfg_wr_sel;
    logic [AW-1:0] cfg_wr_addr;
    logic [DW-1:0] cfg_wr_data;
    logic          start;
    logic [AW:0]   len;
    logic          busy, done, err;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_q_data, m_k_data, m_v_data;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic [AW-1:0] res_rd_addr;
    logic [DW-1:0] res_rd_data;

    attention_stream_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .start(start), .len(len), .busy(busy), .done(done), .err(err),
        .m_valid(m_valid), .m_ready(m_ready), .m_q_data(m_q_data), .m_k_data(m_k_data), .m_v_data(m_v_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Run model: what the host has written, how many beats are still owed each way.
    logic [DW-1:0] mq [DEPTH];
    logic [DW-1:0] mk [DEPTH];
    logic [DW-1:0] mv [DEPTH];
    logic [DW-1:0] mres [DEPTH];
    bit  mdl_ok = 0, mdl_busy = 0, mdl_done = 0, mdl_err = 0;
    int  m_len = 0, m_sent = 0, m_recv = 0, quiet = 0;
    int  last_hs_cyc = 0, last_s_cyc = 0;
    bit  exp_mv, exp_sr, fm, fs;

    logic [DW-1:0] resp_q [$];
    bit  resp_en = 1, resp_sel = 0, rdy_toggle = 0;
    int  dut_m_hs = 0, dut_done_n = 0, dut_done_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        exp_mv = mdl_busy && (m_sent < m_len);
        exp_sr = mdl_busy && (m_recv < m_len);
        if (mdl_ok) begin
            chk("busy",    32'(busy),    32'(mdl_busy));
            chk("done",    32'(done),    32'(mdl_done));
            chk("err",     32'(err),     32'(mdl_err));
            chk("m_valid", 32'(m_valid), 32'(exp_mv));
            chk("s_ready", 32'(s_ready), 32'(exp_sr));
            if (exp_mv) begin
                chk("m_q_data", 32'(m_q_data), 32'(mq[4'(m_sent)]));
                chk("m_k_data", 32'(m_k_data), 32'(mk[4'(m_sent)]));
                chk("m_v_data", 32'(m_v_data), 32'(mv[4'(m_sent)]));
            end
        end
        if (m_valid && m_ready) dut_m_hs++;
        if (done) begin
            dut_done_n++;
            dut_done_cyc = cyc;
        end
        fm = exp_mv && m_ready;
        fs = exp_sr && s_valid;
        if (!rst_n) begin
            mdl_ok = 1; mdl_busy = 0; mdl_done = 0; mdl_err = 0;
            m_len = 0; m_sent = 0; m_recv = 0; quiet = 0;
            resp_q.delete();
        end else begin
            if (cfg_wr_en && !mdl_busy) begin
                case (cfg_wr_sel)
                    2'd0: mq[cfg_wr_addr] = cfg_wr_data;
                    2'd1: mk[cfg_wr_addr] = cfg_wr_data;
                    2'd2: mv[cfg_wr_addr] = cfg_wr_data;
                    default: ;
                endcase
            end
            if (mdl_done) begin
                mdl_done = 0;
            end else if (mdl_busy) begin
                if (fm) begin
                    resp_q.push_back(resp_sel ? mq[4'(m_sent)] : mv[4'(m_sent)]);
                    m_sent++;
                    last_hs_cyc = cyc;
                end
                if (fs) begin
                    mres[4'(m_recv)] = s_data;
                    void'(resp_q.pop_front());
                    m_recv++;
                    last_hs_cyc = cyc;
                    last_s_cyc  = cyc;
                end
                quiet = (fm || fs) ? 0 : quiet + 1;
                if (m_sent == m_len && m_recv == m_len) begin
                    mdl_busy = 0; mdl_done = 1;
                end else if (quiet == TIMEOUT) begin
                    mdl_busy = 0; mdl_done = 1; mdl_err = 1;
                end
            end else if (start) begin
                if (int'(len) >= 1 && int'(len) <= DEPTH) begin
                    mdl_busy = 1; mdl_err = 0; m_len = int'(len);
                    m_sent = 0; m_recv = 0; quiet = 0;
                end else begin
                    mdl_err = 1;
                end
            end
        end
    end

    // Core stand-in: echoes each accepted operand beat one cycle later.
    initial begin
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && resp_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = resp_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
            m_ready = rdy_toggle ? ~m_ready : 1'b1;
        end
    end

    task automatic cfg_write(input logic [1:0] sel, input int addr, input int data);
        cfg_wr_en = 1'b1; cfg_wr_sel = sel; cfg_wr_addr = 4'(addr); cfg_wr_data = 16'(data);
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic do_start(input int l);
        start = 1'b1; len = 5'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: done not seen, got 0 within %0d cycles, expected 1", nm, budget);
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input string nm, input int l);
        do_start(l);
        wait_done(nm, 200);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic rd_check(input string nm, input int addr, input int exp);
        res_rd_addr = 4'(addr);
        @(posedge clk); #1;
        chk(nm, 32'(res_rd_data), 32'(exp));
        chk("res_vs_model", 32'(res_rd_data), 32'(mres[4'(addr)]));
    endtask

    int mark, mark_hs, nb, bud;

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; cfg_wr_en = 1'b0; cfg_wr_sel = '0;
        cfg_wr_addr = '0; cfg_wr_data = '0; res_rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mq[i] = '0; mk[i] = '0; mv[i] = '0; mres[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    32'(busy),        0);
        chk("rst_done",    32'(done),        0);
        chk("rst_err",     32'(err),         0);
        chk("rst_m_valid", 32'(m_valid),     0);
        chk("rst_s_ready", 32'(s_ready),     0);
        chk("rst_rd_data", 32'(res_rd_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            cfg_write(2'd0, i, i + 1);
            cfg_write(2'd1, i, 2);
            cfg_write(2'd2, i, 10 + i);
        end
        cfg_write(2'd3, 0, 16'hdead);

        // T1: plain run, echo V
        mark = dut_done_n;
        run("t1", 4);
        chk("t1_done_lag", 32'(dut_done_cyc - last_s_cyc), 1);
        chk("t1_done_pulses", 32'(dut_done_n - mark), 1);
        rd_check("t1_res0", 0, 10);
        rd_check("t1_res1", 1, 11);
        rd_check("t1_res2", 2, 12);
        rd_check("t1_res3", 3, 13);

        // T2: stalled send channel
        rdy_toggle = 1;
        mark_hs = dut_m_hs;
        run("t2", 4);
        rdy_toggle = 0;
        chk("t2_handshakes", 32'(dut_m_hs - mark_hs), 4);
        rd_check("t2_res3", 3, 13);

        // T3: illegal lengths, then recovery
        do_start(0);
        repeat (2) begin @(posedge clk); #1; end
        chk("t3_err_len0", 32'(err), 1);
        chk("t3_busy_len0", 32'(busy), 0);
        do_start(DEPTH + 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("t3_err_len17", 32'(err), 1);
        run("t3", 2);
        chk("t3_err_cleared", 32'(err), 0);

        // T4: silent responder -> abort after TIMEOUT quiet cycles
        resp_en = 0;
        do_start(3);
        wait_done("t4", TIMEOUT + 200);
        repeat (2) begin @(posedge clk); #1; end
        chk("t4_timeout_lag", 32'(dut_done_cyc - last_hs_cyc), 32'(TIMEOUT + 1));
        chk("t4_err", 32'(err), 1);
        chk("t4_busy", 32'(busy), 0);
        resp_q.delete();
        resp_en = 1;

        // T5: reset after the second send beat
        resp_sel = 1;
        do_start(4);
        nb = 0; bud = 0;
        while (nb < 2 && bud < 50) begin
            @(negedge clk);
            if (m_valid && m_ready) nb++;
            bud++;
        end
        chk("t5_two_beats", 32'(nb), 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_m_valid", 32'(m_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        @(posedge clk); #1;
        run("t5", 4);
        chk("t5_err", 32'(err), 0);
        rd_check("t5_res0", 0, 1);
        rd_check("t5_res3", 3, 4);

        // T6: config writes ignored during RUN, honoured in IDLE
        cfg_write(2'd0, 0, 100);
        do_start(4);
        cfg_write(2'd0, 0, 555);
        wait_done("t6a", 200);
        repeat (2) begin @(posedge clk); #1; end
        rd_check("t6_res0_prerun", 0, 100);
        cfg_write(2'd0, 0, 7);
        run("t6b", 1);
        rd_check("t6_res0_idle_write", 0, 7);

        // Full-depth run
        resp_sel = 0;
        run("t7", DEPTH);
        rd_check("t7_res15", 15, 25);
        rd_check("t7_res0", 0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
